// File: rtl/lsq_pkg.sv
// Shared sizes and the issue record for the LSQ issue arbiter.
package lsq_pkg;

    localparam int NUM_WARPS   = 4;
    localparam int QUEUE_SIZE  = 32;
    localparam int ADDR_WIDTH  = 8;
    localparam int LSQ_CREDITS = QUEUE_SIZE - 1;
    localparam int CW          = $clog2(QUEUE_SIZE) + 1;

    typedef struct packed {
        logic                       instr_bit;
        logic [1:0]                 warp_num;
        logic [3:0]                 dest_reg;
        logic [7:0][ADDR_WIDTH-1:0] addr;
    } lsq_req_t;

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way combinational round-robin arbiter: the first eligible requester
// at or above rr_ptr (modulo 4) wins.
module rr_arbiter4 (
    input  logic [3:0] eligible,
    input  logic [1:0] rr_ptr,
    output logic [3:0] grant
);

    // Walk from the farthest offset down so the nearest eligible one wins last.
    always_comb begin
        grant = '0;
        for (int i = 3; i >= 0; i--) begin
            if (eligible[2'(rr_ptr + 2'(i))]) begin
                grant = 4'(1) << 2'(rr_ptr + 2'(i));
            end
        end
    end

endmodule

// File: rtl/lsq_issue_arbiter.sv
// Arbitrates four warps into the single LSQ write port, tracks LSQ occupancy
// with credits, blocks load WAW hazards per warp and produces writeback strobes.
module lsq_issue_arbiter
    import lsq_pkg::*;
(
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_WARPS-1:0]                      req,
    input  logic [NUM_WARPS-1:0]                      req_instr_bit,
    input  logic [NUM_WARPS-1:0][3:0]                 req_dest_reg,
    input  logic [NUM_WARPS-1:0][7:0][ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_WARPS-1:0]                      grant,
    output logic                                      lsq_write_en,
    output logic [1:0]                                lsq_warp_num,
    output logic [3:0]                                lsq_dest_reg,
    output logic [7:0][ADDR_WIDTH-1:0]                lsq_addr,
    output logic                                      lsq_instr_bit,
    input  logic                                      done_bit_q,
    input  logic [1:0]                                warp_num_out_q,
    input  logic [3:0]                                dest_reg_out_q,
    input  logic                                      instr_bit_out_q,
    output logic                                      wb_valid,
    output logic [1:0]                                wb_warp,
    output logic [3:0]                                wb_dest_reg,
    output logic [NUM_WARPS-1:0]                      warp_busy,
    output logic                                      credit_err
);

    logic [CW-1:0]                 credits;
    logic [NUM_WARPS-1:0][CW-1:0]  outstanding;
    logic [NUM_WARPS-1:0][15:0]    sb;
    logic [NUM_WARPS-1:0][15:0]    sb_nxt;
    logic [1:0]                    rr_ptr;
    logic [NUM_WARPS-1:0]          eligible;
    logic [1:0]                    grant_idx;
    logic                          issue;
    logic                          load_done;
    logic                          credit_full;
    lsq_req_t                      grant_req;

    // Eligibility uses the registered scoreboard only; a same-cycle clear does not unblock.
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            eligible[w] = !reset && req[w] && (credits != '0) &&
                          !(!req_instr_bit[w] && sb[w][req_dest_reg[w]]);
        end
    end

    rr_arbiter4 u_arb (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .grant    (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (grant[w]) grant_idx = 2'(w);
        end
        grant_req.instr_bit = req_instr_bit[grant_idx];
        grant_req.warp_num  = grant_idx;
        grant_req.dest_reg  = req_dest_reg[grant_idx];
        grant_req.addr      = req_addr[grant_idx];
    end

    assign issue       = |grant;
    assign load_done   = done_bit_q && !instr_bit_out_q;
    assign credit_full = (credits == CW'(LSQ_CREDITS));

    // Clear first so an issue to the same bit in the same cycle still marks it pending.
    always_comb begin
        sb_nxt = sb;
        if (load_done) sb_nxt[warp_num_out_q][dest_reg_out_q] = 1'b0;
        if (issue && !grant_req.instr_bit) sb_nxt[grant_idx][grant_req.dest_reg] = 1'b1;
    end

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            warp_busy[w] = (outstanding[w] != '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credits     <= CW'(LSQ_CREDITS);
            outstanding <= '0;
            sb          <= '0;
            rr_ptr      <= '0;
            credit_err  <= 1'b0;
        end else begin
            sb <= sb_nxt;
            if (issue && !done_bit_q) begin
                credits <= credits - CW'(1);
            end else if (done_bit_q && !issue && !credit_full) begin
                credits <= credits + CW'(1);
            end
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (grant[w] && !(done_bit_q && warp_num_out_q == 2'(w))) begin
                    outstanding[w] <= outstanding[w] + CW'(1);
                end else if (!grant[w] && done_bit_q && warp_num_out_q == 2'(w) &&
                             outstanding[w] != '0) begin
                    outstanding[w] <= outstanding[w] - CW'(1);
                end
            end
            if (done_bit_q && (credit_full || outstanding[warp_num_out_q] == '0)) begin
                credit_err <= 1'b1;
            end
            if (issue) rr_ptr <= grant_idx + 2'd1;
        end
    end

    // Output stage: LSQ write port and register-file writeback.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lsq_write_en  <= 1'b0;
            lsq_warp_num  <= '0;
            lsq_dest_reg  <= '0;
            lsq_addr      <= '0;
            lsq_instr_bit <= 1'b0;
            wb_valid      <= 1'b0;
            wb_warp       <= '0;
            wb_dest_reg   <= '0;
        end else begin
            lsq_write_en <= issue;
            if (issue) begin
                lsq_warp_num  <= grant_req.warp_num;
                lsq_dest_reg  <= grant_req.dest_reg;
                lsq_addr      <= grant_req.addr;
                lsq_instr_bit <= grant_req.instr_bit;
            end
            wb_valid <= load_done;
            if (load_done) begin
                wb_warp     <= warp_num_out_q;
                wb_dest_reg <= dest_reg_out_q;
            end
        end
    end

endmodule

// File: tb/tb_lsq_issue_arbiter.sv
// Directed bench for lsq_issue_arbiter: expected LSQ writes and writebacks are
// queued at grant/completion time and popped by an output monitor.
module tb_lsq_issue_arbiter;
    import lsq_pkg::*;

    logic                                      clk = 1'b0;
    logic                                      reset = 1'b1;
    logic [NUM_WARPS-1:0]                      req = '0;
    logic [NUM_WARPS-1:0]                      req_instr_bit = '0;
    logic [NUM_WARPS-1:0][3:0]                 req_dest_reg = '0;
    logic [NUM_WARPS-1:0][7:0][ADDR_WIDTH-1:0] req_addr = '0;
    logic [NUM_WARPS-1:0]                      grant;
    logic                                      lsq_write_en;
    logic [1:0]                                lsq_warp_num;
    logic [3:0]                                lsq_dest_reg;
    logic [7:0][ADDR_WIDTH-1:0]                lsq_addr;
    logic                                      lsq_instr_bit;
    logic                                      done_bit_q = 1'b0;
    logic [1:0]                                warp_num_out_q = '0;
    logic [3:0]                                dest_reg_out_q = '0;
    logic                                      instr_bit_out_q = 1'b0;
    logic                                      wb_valid;
    logic [1:0]                                wb_warp;
    logic [3:0]                                wb_dest_reg;
    logic [NUM_WARPS-1:0]                      warp_busy;
    logic                                      credit_err;

    int checks = 0;
    int errors = 0;

    lsq_req_t   lsq_q[$];
    logic [5:0] wb_q[$];
    lsq_req_t   mon_exp, mon_got;
    logic [5:0] mon_wexp;

    lsq_issue_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .req             (req),
        .req_instr_bit   (req_instr_bit),
        .req_dest_reg    (req_dest_reg),
        .req_addr        (req_addr),
        .grant           (grant),
        .lsq_write_en    (lsq_write_en),
        .lsq_warp_num    (lsq_warp_num),
        .lsq_dest_reg    (lsq_dest_reg),
        .lsq_addr        (lsq_addr),
        .lsq_instr_bit   (lsq_instr_bit),
        .done_bit_q      (done_bit_q),
        .warp_num_out_q  (warp_num_out_q),
        .dest_reg_out_q  (dest_reg_out_q),
        .instr_bit_out_q (instr_bit_out_q),
        .wb_valid        (wb_valid),
        .wb_warp         (wb_warp),
        .wb_dest_reg     (wb_dest_reg),
        .warp_busy       (warp_busy),
        .credit_err      (credit_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Monitor: every LSQ write and writeback strobe must match the queue head.
    always @(negedge clk) begin
        if (!reset) begin
            if (lsq_write_en) begin
                checks++;
                mon_got = lsq_req_t'{lsq_instr_bit, lsq_warp_num, lsq_dest_reg, lsq_addr};
                if (lsq_q.size() == 0) begin
                    errors++;
                    $display("FAIL lsq_unexpected_write got %h", mon_got);
                end else begin
                    mon_exp = lsq_q.pop_front();
                    if (mon_got !== mon_exp) begin
                        errors++;
                        $display("FAIL lsq_write got %h exp %h", mon_got, mon_exp);
                    end
                end
            end
            if (wb_valid) begin
                checks++;
                if (wb_q.size() == 0) begin
                    errors++;
                    $display("FAIL wb_unexpected got warp %0d reg %0d", wb_warp, wb_dest_reg);
                end else begin
                    mon_wexp = wb_q.pop_front();
                    if ({wb_warp, wb_dest_reg} !== mon_wexp) begin
                        errors++;
                        $display("FAIL wb got %h exp %h", {wb_warp, wb_dest_reg}, mon_wexp);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [3:0] g);
        int r = 0;
        for (int i = 0; i < 4; i++) if (g[i]) r = i;
        return r;
    endfunction

    task automatic fill_addr(input int seed);
        for (int w = 0; w < NUM_WARPS; w++)
            for (int t = 0; t < 8; t++)
                req_addr[w][t] = 8'(seed * 7 + w * 40 + t * 3);
    endtask

    // One cycle: check grant mid-cycle, queue what the edge should produce.
    task automatic step(input logic [3:0] exp_g, input string nm);
        int w;
        @(negedge clk);
        checks++;
        if (grant !== exp_g) begin
            errors++;
            $display("FAIL %s grant got %b exp %b", nm, grant, exp_g);
        end
        if (exp_g != 4'b0) begin
            w = onehot_idx(exp_g);
            lsq_q.push_back(lsq_req_t'{req_instr_bit[w], 2'(w), req_dest_reg[w], req_addr[w]});
        end
        if (done_bit_q && !instr_bit_out_q) wb_q.push_back({warp_num_out_q, dest_reg_out_q});
        @(posedge clk);
        #1;
    endtask

    task automatic drain_check(input string nm);
        chk({nm, "_lsq_q_empty"}, 64'(lsq_q.size()), 64'd0);
        chk({nm, "_wb_q_empty"}, 64'(wb_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0;
        req_instr_bit = '0;
        req_dest_reg = '0;
        done_bit_q = 1'b0;
        warp_num_out_q = '0;
        dest_reg_out_q = '0;
        instr_bit_out_q = 1'b0;
        lsq_q.delete();
        wb_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_lsq_write_en", 64'(lsq_write_en), 64'd0);
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_credit_err", 64'(credit_err), 64'd0);
        chk("rst_warp_busy", 64'(warp_busy), 64'd0);
        chk("rst_lsq_fields", {55'(lsq_addr), lsq_warp_num, lsq_dest_reg, lsq_instr_bit}, 64'd0);

        // Continuous stores from all warps exhaust the 31 credits.
        req_instr_bit = 4'hF;
        req_dest_reg = {4'd3, 4'd2, 4'd1, 4'd0};
        req = 4'hF;
        for (int i = 0; i < 31; i++) begin
            fill_addr(i);
            step(4'(1 << (i % 4)), "t1_rr");
        end
        step(4'b0000, "t1_no_credit");
        chk("t1_warp_busy", 64'(warp_busy), 64'hF);
        done_bit_q = 1'b1; warp_num_out_q = 2'd0; instr_bit_out_q = 1'b1;
        step(4'b0000, "t1_done_cycle");
        done_bit_q = 1'b0;
        step(4'b1000, "t1_credit_return");
        step(4'b0000, "t1_empty_again");
        req = '0;
        step(4'b0000, "t1_idle");
        drain_check("t1");

        // Load WAW blocking on warp 1, r5.
        do_reset();
        req_instr_bit = '0;
        req_dest_reg[1] = 4'd5;
        fill_addr(50);
        req = 4'b0010;
        step(4'b0010, "t2_load");
        chk("t2_busy", 64'(warp_busy), 64'b0010);
        step(4'b0000, "t2_waw_block_a");
        step(4'b0000, "t2_waw_block_b");
        done_bit_q = 1'b1; warp_num_out_q = 2'd1; dest_reg_out_q = 4'd5; instr_bit_out_q = 1'b0;
        step(4'b0000, "t2_block_on_done_cycle");
        done_bit_q = 1'b0;
        step(4'b0010, "t2_regrant");
        req = '0;
        step(4'b0000, "t2_idle");

        // Stores bypass the scoreboard; other registers are unaffected.
        req_dest_reg[2] = 4'd3;
        req_instr_bit[2] = 1'b0;
        req = 4'b0100;
        step(4'b0100, "t3_load_r3");
        req_instr_bit[2] = 1'b1;
        fill_addr(60);
        step(4'b0100, "t3_store_r3");
        req_instr_bit[2] = 1'b0;
        req_dest_reg[2] = 4'd4;
        step(4'b0100, "t3_load_r4");
        req_dest_reg[2] = 4'd3;
        step(4'b0000, "t3_load_r3_blocked");
        req = '0;
        step(4'b0000, "t3_idle");
        chk("t3_busy", 64'(warp_busy), 64'b0110);
        drain_check("t3");

        // Same-cycle issue and completion at credits 10 leaves credits at 10.
        do_reset();
        req_instr_bit = 4'hF;
        req_dest_reg[0] = 4'd9;
        req = 4'b0001;
        for (int i = 0; i < 21; i++) begin
            fill_addr(100 + i);
            step(4'b0001, "t4_fill");
        end
        done_bit_q = 1'b1; warp_num_out_q = 2'd0; instr_bit_out_q = 1'b1;
        step(4'b0001, "t4_same_cycle");
        done_bit_q = 1'b0;
        chk("t4_wb_valid", 64'(wb_valid), 64'd0);
        for (int i = 0; i < 10; i++) begin
            fill_addr(200 + i);
            step(4'b0001, "t4_remaining");
        end
        step(4'b0000, "t4_exhausted");
        chk("t4_busy", 64'(warp_busy), 64'b0001);
        req = '0;
        step(4'b0000, "t4_idle");
        drain_check("t4");

        // Spurious completion: sticky error, counters saturate.
        do_reset();
        done_bit_q = 1'b1; warp_num_out_q = 2'd3; instr_bit_out_q = 1'b1;
        step(4'b0000, "t5_spurious_done");
        done_bit_q = 1'b0;
        chk("t5_credit_err", 64'(credit_err), 64'd1);
        chk("t5_busy_sat", 64'(warp_busy), 64'd0);
        step(4'b0000, "t5_hold_a");
        step(4'b0000, "t5_hold_b");
        chk("t5_credit_err_sticky", 64'(credit_err), 64'd1);
        req_instr_bit = 4'hF;
        req = 4'hF;
        for (int i = 0; i < 31; i++) begin
            fill_addr(300 + i);
            step(4'(1 << (i % 4)), "t5_burst");
        end
        step(4'b0000, "t5_credits_31_only");
        done_bit_q = 1'b1; warp_num_out_q = 2'd0; instr_bit_out_q = 1'b1;
        step(4'b0000, "t5_done");
        done_bit_q = 1'b0;
        step(4'b1000, "t5_one_more");
        chk("t5_credit_err_after", 64'(credit_err), 64'd1);
        chk("t5_write_en_before_reset", 64'(lsq_write_en), 64'd1);

        // Asynchronous reset mid-burst, between clock edges, requests still held.
        #1 reset = 1'b1;
        lsq_q.delete();
        wb_q.delete();
        #1;
        chk("mr_grant", 64'(grant), 64'd0);
        chk("mr_lsq_write_en", 64'(lsq_write_en), 64'd0);
        chk("mr_lsq_fields", {55'(lsq_addr), lsq_warp_num, lsq_dest_reg, lsq_instr_bit}, 64'd0);
        chk("mr_wb", {wb_valid, wb_warp, wb_dest_reg}, 64'd0);
        chk("mr_credit_err", 64'(credit_err), 64'd0);
        chk("mr_warp_busy", 64'(warp_busy), 64'd0);
        do_reset();
        step(4'b0000, "mr_idle_after");
        drain_check("end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
